// File: rtl/ram_responder_if.sv
// Bus bundle between the control sequencer/SRAM pins and ram_responder.
// The slave modport is the responder's view; the master modport is the driver's view.
interface ram_responder_if;
    // Control strobes from the sequencer
    logic       i_ctrlRamAddressEn;
    logic       i_ctrlRamWriteNEn;
    logic       i_ctrlRamOE;
    logic       i_ctrlRamReadDataSelect;
    logic       i_errClr;
    // System bus
    logic [7:0] i_bus;
    logic [7:0] o_bus;
    logic       o_busOe;
    logic [7:0] o_instruction;
    // External async SRAM
    logic [7:0] o_sramAddr;
    logic [7:0] o_sramData;
    logic       o_sramDataOe;
    logic [7:0] i_sramData;
    logic       o_sramNWe;
    logic       o_sramNOe;
    // Status
    logic       o_busy;
    logic       o_error;

    modport slave (
        input  i_ctrlRamAddressEn,
        input  i_ctrlRamWriteNEn,
        input  i_ctrlRamOE,
        input  i_ctrlRamReadDataSelect,
        input  i_errClr,
        input  i_bus,
        input  i_sramData,
        output o_bus,
        output o_busOe,
        output o_instruction,
        output o_sramAddr,
        output o_sramData,
        output o_sramDataOe,
        output o_sramNWe,
        output o_sramNOe,
        output o_busy,
        output o_error
    );

    modport master (
        output i_ctrlRamAddressEn,
        output i_ctrlRamWriteNEn,
        output i_ctrlRamOE,
        output i_ctrlRamReadDataSelect,
        output i_errClr,
        output i_bus,
        output i_sramData,
        input  o_bus,
        input  o_busOe,
        input  o_instruction,
        input  o_sramAddr,
        input  o_sramData,
        input  o_sramDataOe,
        input  o_sramNWe,
        input  o_sramNOe,
        input  o_busy,
        input  o_error
    );
endinterface

// File: rtl/ram_responder.sv
// RAM responder: address/instruction registers, zero-cycle bus reads and a
// setup/pulse/hold write sequencer for an external asynchronous SRAM.
module ram_responder #(
    parameter int unsigned WR_PULSE_CYCLES = 2  // cycles nWe is low per write, 1..7
) (
    input logic            i_clk,
    input logic            i_nReset,
    ram_responder_if.slave bus_if
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWSetup = 2'd1;
    localparam logic [1:0] StWPulse = 2'd2;
    localparam logic [1:0] StWHold  = 2'd3;

    // Counter reload value: the pulse state ends on the cycle the counter reads zero.
    localparam logic [2:0] PulseLast = 3'(WR_PULSE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] w_wdata_nxt;
    logic [7:0] r_instr;
    logic       r_error;
    logic       w_error_nxt;

    logic       w_idle;
    logic       w_wr_req;
    logic       w_violation;

    assign w_idle   = (r_state == StIdle);
    assign w_wr_req = ~bus_if.i_ctrlRamWriteNEn;

    // Violations: address load colliding with a write request while idle, or any
    // control strobe arriving while a write sequence owns the SRAM.
    assign w_violation =
        (w_idle & bus_if.i_ctrlRamAddressEn & w_wr_req) |
        (~w_idle & (bus_if.i_ctrlRamAddressEn | w_wr_req |
                    bus_if.i_ctrlRamOE | bus_if.i_ctrlRamReadDataSelect));

    // Write sequencer next-state, pulse counter and write-data capture
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wdata_nxt = r_wdata;
        unique case (r_state)
            StIdle: begin
                // An address load on the same edge wins; the write is dropped.
                if (w_wr_req && !bus_if.i_ctrlRamAddressEn) begin
                    w_wdata_nxt = bus_if.i_bus;
                    w_state_nxt = StWSetup;
                end
            end
            StWSetup: begin
                w_cnt_nxt   = PulseLast;
                w_state_nxt = StWPulse;
            end
            StWPulse: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = StWHold;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            StWHold: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Sticky error: a fresh violation outranks a clear on the same edge
    always_comb begin
        w_error_nxt = r_error;
        if (w_violation) begin
            w_error_nxt = 1'b1;
        end else if (bus_if.i_errClr) begin
            w_error_nxt = 1'b0;
        end
    end

    // Sequencer state, counter and write-data registers
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
            r_wdata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Address register: loaded only while the SRAM is not mid-write
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_addr <= 8'h00;
        end else if (w_idle && bus_if.i_ctrlRamAddressEn) begin
            r_addr <= bus_if.i_bus;
        end
    end

    // Instruction register: fetches the byte currently presented by the SRAM
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_instr <= 8'h00;
        end else if (w_idle && bus_if.i_ctrlRamReadDataSelect) begin
            r_instr <= bus_if.i_sramData;
        end
    end

    // Error flag register
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_error_nxt;
        end
    end

    // Outputs decode from state so reset forces nWe high without waiting for a clock
    always_comb begin
        bus_if.o_sramAddr    = r_addr;
        bus_if.o_sramData    = r_wdata;
        bus_if.o_sramDataOe  = ~w_idle;
        bus_if.o_sramNOe     = ~w_idle;
        bus_if.o_sramNWe     = (r_state != StWPulse);
        bus_if.o_busy        = ~w_idle;
        bus_if.o_error       = r_error;
        bus_if.o_instruction = r_instr;
        bus_if.o_bus         = bus_if.i_sramData;
        bus_if.o_busOe       = bus_if.i_ctrlRamOE & ~bus_if.i_ctrlRamReadDataSelect & w_idle;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: writes are pushed to a scoreboard when
// requested and checked when the SRAM write strobe falls.
module tb_ram_responder;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic i_clk;
    logic i_nReset;

    int   n_vec;
    int   n_err;
    wr_t  sb_q[$];
    logic prev_nwe;

    ram_responder_if bif2 ();
    ram_responder_if bif1 ();

    ram_responder #(.WR_PULSE_CYCLES(2)) dut2 (
        .i_clk    (i_clk),
        .i_nReset (i_nReset),
        .bus_if   (bif2.slave)
    );

    ram_responder #(.WR_PULSE_CYCLES(1)) dut1 (
        .i_clk    (i_clk),
        .i_nReset (i_nReset),
        .bus_if   (bif1.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard consumer: each falling nWe on the P=2 instance is one write
    always @(negedge i_clk) begin
        if (prev_nwe && !bif2.o_sramNWe) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(bif2.o_sramData), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_addr", 32'(bif2.o_sramAddr), 32'(e.addr));
                chk("sb_data", 32'(bif2.o_sramData), 32'(e.data));
            end
        end
        prev_nwe = bif2.o_sramNWe;
    end

    initial begin
        int busy_cnt;
        int low_cnt;
        int pulses;
        logic prev;

        n_vec    = 0;
        n_err    = 0;
        prev_nwe = 1'b1;
        i_nReset = 1'b0;
        bif2.i_ctrlRamAddressEn      = 1'b0;
        bif2.i_ctrlRamWriteNEn       = 1'b1;
        bif2.i_ctrlRamOE             = 1'b0;
        bif2.i_ctrlRamReadDataSelect = 1'b0;
        bif2.i_errClr                = 1'b0;
        bif2.i_bus                   = 8'h00;
        bif2.i_sramData              = 8'h00;
        bif1.i_ctrlRamAddressEn      = 1'b0;
        bif1.i_ctrlRamWriteNEn       = 1'b1;
        bif1.i_ctrlRamOE             = 1'b0;
        bif1.i_ctrlRamReadDataSelect = 1'b0;
        bif1.i_errClr                = 1'b0;
        bif1.i_bus                   = 8'h00;
        bif1.i_sramData              = 8'h00;

        // Reset state
        #3;
        chk("rst_nwe",    32'(bif2.o_sramNWe),    32'd1);
        chk("rst_busy",   32'(bif2.o_busy),       32'd0);
        chk("rst_dataoe", 32'(bif2.o_sramDataOe), 32'd0);
        chk("rst_error",  32'(bif2.o_error),      32'd0);
        chk("rst_addr",   32'(bif2.o_sramAddr),   32'd0);
        #9;
        i_nReset = 1'b1;
        tick();

        // Address load then write 0xA5
        bif2.i_ctrlRamAddressEn = 1'b1;
        bif2.i_bus              = 8'h3C;
        tick();
        chk("addr_load", 32'(bif2.o_sramAddr), 32'h3C);
        bif2.i_ctrlRamAddressEn = 1'b0;
        bif2.i_ctrlRamWriteNEn  = 1'b0;
        bif2.i_bus              = 8'hA5;
        sb_q.push_back('{addr: 8'h3C, data: 8'hA5});
        tick();
        bif2.i_ctrlRamWriteNEn = 1'b1;
        chk("setup_busy",   32'(bif2.o_busy),       32'd1);
        chk("setup_nwe",    32'(bif2.o_sramNWe),    32'd1);
        chk("setup_dataoe", 32'(bif2.o_sramDataOe), 32'd1);
        chk("setup_noe",    32'(bif2.o_sramNOe),    32'd1);
        chk("setup_data",   32'(bif2.o_sramData),   32'hA5);
        busy_cnt = 1;
        low_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bif2.o_busy) break;
            busy_cnt++;
            if (!bif2.o_sramNWe) low_cnt++;
        end
        chk("write_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("write_nwe_cycles",  32'(low_cnt),  32'd2);
        chk("write_idle_noe",    32'(bif2.o_sramNOe), 32'd0);
        chk("write_no_error",    32'(bif2.o_error),   32'd0);

        // Zero-cycle bus read, then instruction fetch
        bif2.i_sramData  = 8'h5A;
        bif2.i_ctrlRamOE = 1'b1;
        #1;
        chk("read_busoe", 32'(bif2.o_busOe), 32'd1);
        chk("read_bus",   32'(bif2.o_bus),   32'h5A);
        bif2.i_ctrlRamReadDataSelect = 1'b1;
        #1;
        chk("fetch_busoe", 32'(bif2.o_busOe), 32'd0);
        tick();
        chk("fetch_instr", 32'(bif2.o_instruction), 32'h5A);
        bif2.i_ctrlRamOE             = 1'b0;
        bif2.i_ctrlRamReadDataSelect = 1'b0;

        // Address/write collision
        bif2.i_ctrlRamAddressEn = 1'b1;
        bif2.i_ctrlRamWriteNEn  = 1'b0;
        bif2.i_bus              = 8'h77;
        tick();
        bif2.i_ctrlRamAddressEn = 1'b0;
        bif2.i_ctrlRamWriteNEn  = 1'b1;
        chk("coll_addr",  32'(bif2.o_sramAddr), 32'h77);
        chk("coll_busy",  32'(bif2.o_busy),     32'd0);
        chk("coll_error", 32'(bif2.o_error),    32'd1);
        tick();
        chk("coll_no_write", 32'(bif2.o_busy), 32'd0);
        bif2.i_errClr = 1'b1;
        tick();
        chk("errclr", 32'(bif2.o_error), 32'd0);
        // Clear and new violation on the same edge: error stays set
        bif2.i_ctrlRamAddressEn = 1'b1;
        bif2.i_ctrlRamWriteNEn  = 1'b0;
        tick();
        chk("errclr_vs_violation", 32'(bif2.o_error), 32'd1);
        bif2.i_ctrlRamAddressEn = 1'b0;
        bif2.i_ctrlRamWriteNEn  = 1'b1;
        tick();
        bif2.i_errClr = 1'b0;
        chk("errclr_again", 32'(bif2.o_error), 32'd0);

        // Address load attempted mid-pulse
        bif2.i_ctrlRamWriteNEn = 1'b0;
        bif2.i_bus             = 8'hC3;
        sb_q.push_back('{addr: 8'h77, data: 8'hC3});
        tick();
        bif2.i_ctrlRamWriteNEn = 1'b1;
        tick();
        chk("pulse_nwe", 32'(bif2.o_sramNWe), 32'd0);
        bif2.i_ctrlRamAddressEn = 1'b1;
        bif2.i_ctrlRamOE        = 1'b1;
        bif2.i_bus              = 8'h11;
        #1;
        chk("busy_busoe", 32'(bif2.o_busOe), 32'd0);
        tick();
        bif2.i_ctrlRamAddressEn = 1'b0;
        bif2.i_ctrlRamOE        = 1'b0;
        chk("busy_addr_kept", 32'(bif2.o_sramAddr), 32'h77);
        chk("busy_error",     32'(bif2.o_error),    32'd1);
        for (int i = 0; i < 10; i++) begin
            if (!bif2.o_busy) break;
            tick();
        end
        chk("drain_busy", 32'(bif2.o_busy), 32'd0);
        bif2.i_errClr = 1'b1;
        tick();
        bif2.i_errClr = 1'b0;

        // Reset asserted mid-pulse
        bif2.i_ctrlRamWriteNEn = 1'b0;
        bif2.i_bus             = 8'h99;
        sb_q.push_back('{addr: 8'h77, data: 8'h99});
        tick();
        bif2.i_ctrlRamWriteNEn = 1'b1;
        tick();
        @(negedge i_clk);
        #1;
        i_nReset = 1'b0;
        #1;
        chk("arst_nwe",   32'(bif2.o_sramNWe),      32'd1);
        chk("arst_busy",  32'(bif2.o_busy),         32'd0);
        chk("arst_addr",  32'(bif2.o_sramAddr),     32'd0);
        chk("arst_data",  32'(bif2.o_sramData),     32'd0);
        chk("arst_instr", 32'(bif2.o_instruction),  32'd0);
        chk("arst_error", 32'(bif2.o_error),        32'd0);
        #1;
        i_nReset = 1'b1;
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Held write request at one-cycle pulse width
        bif1.i_ctrlRamWriteNEn = 1'b0;
        bif1.i_bus             = 8'h42;
        pulses = 0;
        prev   = bif1.o_sramNWe;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (prev && !bif1.o_sramNWe) pulses++;
            prev = bif1.o_sramNWe;
        end
        bif1.i_ctrlRamWriteNEn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (prev && !bif1.o_sramNWe) pulses++;
            prev = bif1.o_sramNWe;
        end
        chk("b2b_writes", 32'(pulses),        32'd3);
        chk("b2b_idle",   32'(bif1.o_busy),   32'd0);
        chk("b2b_nwe",    32'(bif1.o_sramNWe), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter WR_PULSE_CYCLES, default 2, the number of clock cycles o_sramNWe is held low per write (legal values 1..7).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_nReset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_ctrlRamAddressEn, input, 1 bit: load i_bus into the address register.
REQ-005 SHALL have port i_ctrlRamWriteNEn, input, 1 bit: active-low write request; data is taken from i_bus.
REQ-006 SHALL have port i_ctrlRamOE, input, 1 bit: drive read data onto the bus.
REQ-007 SHALL have port i_ctrlRamReadDataSelect, input, 1 bit: route read data to the instruction register instead of the bus.
REQ-008 SHALL have port i_errClr, input, 1 bit: synchronous clear of o_error.
REQ-009 SHALL have port i_bus, input, 8 bits: system data bus.
REQ-010 SHALL have port o_bus, output, 8 bits: read data toward the bus.
REQ-011 SHALL have port o_busOe, output, 1 bit: o_bus valid and driving.
REQ-012 SHALL have port o_instruction, output, 8 bits: fetched instruction byte.
REQ-013 SHALL have port o_sramAddr, output, 8 bits: external async SRAM address.
REQ-014 SHALL have port o_sramData, output, 8 bits: SRAM write data.
REQ-015 SHALL have port o_sramDataOe, output, 1 bit: drive o_sramData onto the SRAM data pins.
REQ-016 SHALL have port i_sramData, input, 8 bits: SRAM read data.
REQ-017 SHALL have port o_sramNWe, output, 1 bit: SRAM write enable, active low.
REQ-018 SHALL have port o_sramNOe, output, 1 bit: SRAM output enable, active low.
REQ-019 SHALL have port o_busy, output, 1 bit: write sequence in progress.
REQ-020 SHALL have port o_error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-021 SHALL implement write FSM states IDLE, W_SETUP, W_PULSE, W_HOLD.
REQ-022 SHALL, in IDLE with i_ctrlRamWriteNEn=0 and i_ctrlRamAddressEn=0, capture i_bus into the write-data register and enter W_SETUP.
REQ-023 SHALL hold W_SETUP 1 cycle: o_sramDataOe=1, o_sramNWe=1, o_sramNOe=1.
REQ-024 SHALL hold W_PULSE exactly WR_PULSE_CYCLES cycles with o_sramNWe=0 and o_sramDataOe=1, counted by a 3-bit down-counter.
REQ-025 SHALL hold W_HOLD 1 cycle: o_sramNWe=1, o_sramDataOe=1; then return to IDLE.
REQ-026 SHALL drive o_busy=1 in every state other than IDLE; a write occupies WR_PULSE_CYCLES+2 cycles.
REQ-027 SHALL, in IDLE, drive o_sramNOe=0 and o_sramDataOe=0; o_sramAddr SHALL always equal the address register.
REQ-028 SHALL load the address register from i_bus at the edge when i_ctrlRamAddressEn=1 and the FSM is in IDLE.
REQ-029 SHALL drive o_busOe = i_ctrlRamOE & ~i_ctrlRamReadDataSelect & IDLE, with o_bus = i_sramData combinationally (zero-cycle read).
REQ-030 SHALL load o_instruction from i_sramData at the edge when i_ctrlRamReadDataSelect=1 and the FSM is in IDLE.
REQ-031 SHALL, when i_ctrlRamAddressEn=1 and i_ctrlRamWriteNEn=0 on the same edge in IDLE, load the address, ignore the write, and set o_error.
REQ-032 SHALL, while o_busy=1, ignore i_ctrlRamAddressEn, i_ctrlRamWriteNEn=0, i_ctrlRamOE and i_ctrlRamReadDataSelect; each SHALL set o_error, and o_busOe SHALL stay 0.
REQ-033 SHALL start a new write on the first IDLE edge on which i_ctrlRamWriteNEn is low; a request held low continuously SHALL start back-to-back writes.
REQ-034 SHALL clear o_error on an edge with i_errClr=1 unless a new violation occurs on that same edge, in which case o_error SHALL remain 1.

Reset
REQ-035 SHALL, on i_nReset=0 and regardless of the clock, enter IDLE and set the address, write-data, instruction and counter registers to 0, with o_error=0, o_busy=0, o_sramNWe=1, o_sramDataOe=0.
REQ-036 SHALL abort any write in progress when reset is asserted, returning o_sramNWe to 1 asynchronously.

Verification
REQ-037 SHALL be tested with address-load 0x3C, then write with bus=0xA5, WR_PULSE_CYCLES=2 -> nWe low for exactly 2 cycles, sramAddr=0x3C, sramData=0xA5, busy high for 4 cycles.
REQ-038 SHALL be tested with sramData=0x5A, RamOE=1, ReadDataSelect=0 in IDLE -> o_busOe=1 and o_bus=0x5A in the same cycle; with ReadDataSelect=1 -> o_instruction=0x5A after the edge and o_busOe=0.
REQ-039 SHALL be tested with AddressEn=1, WriteNEn=0 and bus=0x77 on the same edge -> address becomes 0x77, no write occurs, o_error=1; then i_errClr -> o_error=0.
REQ-040 SHALL be tested with AddressEn asserted during W_PULSE -> address unchanged and o_error=1.
REQ-041 SHALL be tested with i_nReset driven low mid-W_PULSE -> nWe=1 and busy=0 immediately, and all registers 0.
REQ-042 SHALL be tested with WriteNEn held low for 10 cycles at WR_PULSE_CYCLES=1 -> 3 complete writes, with nWe high in between.
